jtl_delay_meter: RTL
====================

JTL_DELAY_METER -- requirements
Module: jtl_delay_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the delay counter and result.
REQ-002 SHALL have parameter TIMEOUT, default 1000, the maximum delay in clk cycles before a measurement aborts; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_evt, input, 1, toggle-coded stimulus line that drives the JTL input; each level change is one event.
REQ-006 SHALL have port out_evt, input, 1, toggle-coded JTL output line; each level change is one event.
REQ-007 SHALL have port arm, input, 1, one-cycle request to start a measurement.
REQ-008 SHALL have port busy, output, 1, high while a measurement is armed or in progress.
REQ-009 SHALL have port delay, output, CNT_W, the last measured delay in clk cycles.
REQ-010 SHALL have port valid, output, 1, one-cycle strobe that marks a new delay value.
REQ-011 SHALL have port timeout, output, 1, one-cycle strobe that marks an aborted measurement.
REQ-012 SHALL have port err, output, 1, sticky flag for an unexpected out_evt event.
REQ-013 SHALL have port evt_cnt, output, 8, count of out_evt events since reset; wraps modulo 256.

Function
REQ-014 SHALL pass in_evt and out_evt through identical 2-flop synchronizers.
REQ-015 SHALL detect an event in a cycle where a synchronized line differs from its previous synchronized value.
REQ-016 SHALL implement four states: IDLE, ARMED, MEASURE, DONE.
REQ-017 IDLE: arm=1 SHALL go to ARMED; busy=0.
REQ-018 ARMED: an in-event without an out-event in the same cycle SHALL clear the counter to 0 and go to MEASURE; busy=1.
REQ-019 ARMED: in-event and out-event in the same cycle SHALL load delay=0 and go to DONE.
REQ-020 ARMED: an out-event without an in-event SHALL set err and remain in ARMED.
REQ-021 MEASURE: the counter SHALL increment by 1 every cycle.
REQ-022 MEASURE: an out-event SHALL load delay with counter+1 and go to DONE; delay is therefore the cycle distance between the two detected events.
REQ-023 MEASURE: counter+1 reaching TIMEOUT without an out-event SHALL load delay=TIMEOUT, pulse timeout for 1 cycle, and go to IDLE.
REQ-024 MEASURE: the counter SHALL never exceed TIMEOUT and never wrap.
REQ-025 MEASURE: a further in-event SHALL be ignored and SHALL NOT restart the count.
REQ-026 DONE: valid SHALL be 1 for exactly this one cycle, then the block SHALL go to IDLE.
REQ-027 delay SHALL hold its value until the next valid or timeout.
REQ-028 arm SHALL be ignored in every state except IDLE.
REQ-029 An out-event in IDLE or DONE SHALL set err.
REQ-030 err SHALL clear only on reset.
REQ-031 evt_cnt SHALL increment on every out-event, in any state.
REQ-032 busy SHALL be 1 in ARMED and MEASURE, and 0 in IDLE and DONE.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE
- synchronizers, counter, delay, evt_cnt = 0
- valid, timeout, err, busy = 0
REQ-034 Reset asserted mid-measurement SHALL abort with no valid or timeout strobe.
REQ-035 After reset, the first edge-detect SHALL compare against the reset value 0, so an input already high at reset release SHALL count as an event.

Verification
REQ-036 Normal case: arm, toggle in_evt, toggle out_evt 7 cycles later -> valid=1 for 1 cycle, delay=7, busy=0 afterwards, evt_cnt=1.
REQ-037 Simultaneous events: arm, toggle in_evt and out_evt in the same cycle -> valid pulse, delay=0.
REQ-038 Timeout: TIMEOUT=20, arm, toggle in_evt, no out_evt -> timeout pulse 20 cycles after the in-event, delay=20, no valid.
REQ-039 Spurious output: toggle out_evt in IDLE, then arm plus a normal 3-cycle measurement -> err=1 and stays 1, delay=3, evt_cnt=2.
REQ-040 Re-arm and reset mid-measurement:
- arm pulsed during MEASURE has no effect
- rst_n low 3 cycles into MEASURE -> all outputs 0, no strobe, next arm measures correctly.

Source files
------------

// File: rtl/jtl_delay_meter.sv
// -----------------------------------------------------------------------------
// jtl_delay_meter
// Measures the propagation delay, in clk cycles, of a Josephson transmission
// line. The stimulus and response lines are both toggle-coded, so every level
// change on either line is one event. After an arm request, the next input
// event starts a counter and the next output event stops it. A measurement
// that runs for TIMEOUT cycles with no output event is aborted.
//
// Parameters
//   CNT_W    width of the delay counter and of the result
//   TIMEOUT  longest delay before a measurement aborts (1 .. 2^CNT_W-1)
//
// Ports
//   clk      single clock; all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   in_evt   toggle-coded stimulus line (JTL input)
//   out_evt  toggle-coded response line (JTL output)
//   arm      one-cycle request to start a measurement (used only in IDLE)
//   busy     high while armed or measuring
//   delay    last measured delay; held until the next valid or timeout
//   valid    one-cycle strobe marking a new delay value
//   timeout  one-cycle strobe marking an aborted measurement
//   err      sticky flag for an out_evt event nobody was waiting for
//   evt_cnt  count of out_evt events since reset, wraps modulo 256
// -----------------------------------------------------------------------------
module jtl_delay_meter #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_evt,
   input  logic             out_evt,
   input  logic             arm,
   output logic             busy,
   output logic [CNT_W-1:0] delay,
   output logic             valid,
   output logic             timeout,
   output logic             err,
   output logic [7:0]       evt_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic [1:0]       in_sync, out_sync;
   logic             in_prev, out_prev;
   logic             in_ev, out_ev;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [CNT_W-1:0] delay_nxt;
   logic             timeout_nxt;
   logic             err_nxt;

   // Two-flop synchronizers plus a previous-value flop for edge detection.
   // The previous-value flops reset to 0, so a line already high when reset
   // releases produces one event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_sync  <= '0;
         out_sync <= '0;
         in_prev  <= 1'b0;
         out_prev <= 1'b0;
      end else begin
         in_sync  <= {in_sync[0], in_evt};
         out_sync <= {out_sync[0], out_evt};
         in_prev  <= in_sync[1];
         out_prev <= out_sync[1];
      end
   end

   assign in_ev   = in_sync[1] ^ in_prev;
   assign out_ev  = out_sync[1] ^ out_prev;
   assign cnt_inc = cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      delay_nxt   = delay;
      timeout_nxt = 1'b0;
      err_nxt     = err;
      busy        = 1'b0;
      valid       = 1'b0;
      case (state)
         IDLE: begin
            if (out_ev) err_nxt = 1'b1;
            if (arm) state_nxt = ARMED;
         end
         ARMED: begin
            busy = 1'b1;
            if (in_ev && out_ev) begin
               delay_nxt = '0;
               state_nxt = DONE;
            end else if (in_ev) begin
               cnt_nxt   = '0;
               state_nxt = MEASURE;
            end else if (out_ev) begin
               err_nxt = 1'b1;
            end
         end
         MEASURE: begin
            busy    = 1'b1;
            cnt_nxt = cnt_inc;
            // An output event on the very cycle the limit is reached still
            // counts as a completed measurement.
            if (out_ev) begin
               delay_nxt = cnt_inc;
               state_nxt = DONE;
            end else if (cnt_inc == TIMEOUT_V) begin
               delay_nxt   = TIMEOUT_V;
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         DONE: begin
            valid     = 1'b1;
            if (out_ev) err_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         delay   <= '0;
         timeout <= 1'b0;
         err     <= 1'b0;
         evt_cnt <= '0;
      end else begin
         cnt     <= cnt_nxt;
         delay   <= delay_nxt;
         timeout <= timeout_nxt;
         err     <= err_nxt;
         evt_cnt <= evt_cnt + {7'd0, out_ev};
      end
   end

endmodule
